// File: rtl/spi_master.sv
// Mode-0 SPI master: one DATA_WIDTH-bit full-duplex frame per valid/ready handshake, MSB first.
// sclk comes from an internal divider (CLK_DIV clk cycles per sclk half-period).
module spi_master #(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic                  rx_valid,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  busy,
   output logic                  sclk,
   output logic                  mosi,
   input  logic                  miso,
   output logic                  ss
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CNT_W = $clog2(DATA_WIDTH + 1);

   if (CLK_DIV < 2 || DATA_WIDTH < 2) begin : g_param_check
      $error("spi_master: CLK_DIV and DATA_WIDTH must both be >= 2");
   end

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_HIGH  = 3'd2,
      ST_LOW   = 3'd3,
      ST_HOLD  = 3'd4
   } state_t;

   state_t                state_r, state_s;
   logic [DIV_W-1:0]      div_r, div_s;
   logic [CNT_W-1:0]      bit_cnt_r, bit_cnt_s;
   logic [DATA_WIDTH-1:0] tx_sh_r, tx_sh_s;
   logic [DATA_WIDTH-1:0] rx_sh_r, rx_sh_s;
   logic [DATA_WIDTH-1:0] rx_data_r, rx_data_s;
   logic                  sclk_r, sclk_s;
   logic                  mosi_r, mosi_s;
   logic                  ss_r, ss_s;
   logic                  rx_valid_r, rx_valid_s;
   logic                  tx_ready_r, tx_ready_s;
   logic                  busy_r, busy_s;
   logic                  tc_s;

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      state_s    = state_r;
      div_s      = div_r;
      bit_cnt_s  = bit_cnt_r;
      tx_sh_s    = tx_sh_r;
      rx_sh_s    = rx_sh_r;
      rx_data_s  = rx_data_r;
      sclk_s     = sclk_r;
      mosi_s     = mosi_r;
      ss_s       = ss_r;
      rx_valid_s = 1'b0;
      tx_ready_s = tx_ready_r;
      busy_s     = busy_r;
      tc_s       = (div_r == DIV_W'(CLK_DIV - 1));

      if (tc_s) begin
         div_s = {DIV_W{1'b0}};
      end else begin
         div_s = div_r + DIV_W'(1);
      end

      case (state_r)
         ST_IDLE: begin
            div_s = {DIV_W{1'b0}};
            if (tx_valid && tx_ready_r) begin
               state_s    = ST_SETUP;
               tx_sh_s    = tx_data;
               mosi_s     = tx_data[DATA_WIDTH-1];
               ss_s       = 1'b0;
               sclk_s     = 1'b0;
               bit_cnt_s  = {CNT_W{1'b0}};
               tx_ready_s = 1'b0;
               busy_s     = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         // SETUP and LOW both end in a rising sclk edge that samples miso.
         ST_SETUP, ST_LOW: begin
            if (tc_s) begin
               state_s   = ST_HIGH;
               sclk_s    = 1'b1;
               rx_sh_s   = {rx_sh_r[DATA_WIDTH-2:0], miso};
               bit_cnt_s = bit_cnt_r + CNT_W'(1);
            end else begin
               state_s = state_r;
            end
         end
         ST_HIGH: begin
            if (tc_s) begin
               sclk_s = 1'b0;
               if (bit_cnt_r < CNT_W'(DATA_WIDTH)) begin
                  state_s = ST_LOW;
                  mosi_s  = tx_sh_r[DATA_WIDTH-2];
                  tx_sh_s = tx_sh_r << 1;
               end else begin
                  state_s = ST_HOLD;
               end
            end else begin
               state_s = ST_HIGH;
            end
         end
         ST_HOLD: begin
            if (tc_s) begin
               state_s    = ST_IDLE;
               ss_s       = 1'b1;
               mosi_s     = 1'b0;
               rx_data_s  = rx_sh_r;
               rx_valid_s = 1'b1;
               tx_ready_s = 1'b1;
               busy_s     = 1'b0;
            end else begin
               state_s = ST_HOLD;
            end
         end
         default: begin
            state_s    = ST_IDLE;
            div_s      = {DIV_W{1'b0}};
            ss_s       = 1'b1;
            sclk_s     = 1'b0;
            mosi_s     = 1'b0;
            tx_ready_s = 1'b1;
            busy_s     = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous reset (abort is immediate).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         div_r      <= {DIV_W{1'b0}};
         bit_cnt_r  <= {CNT_W{1'b0}};
         tx_sh_r    <= {DATA_WIDTH{1'b0}};
         rx_sh_r    <= {DATA_WIDTH{1'b0}};
         rx_data_r  <= {DATA_WIDTH{1'b0}};
         sclk_r     <= 1'b0;
         mosi_r     <= 1'b0;
         ss_r       <= 1'b1;
         rx_valid_r <= 1'b0;
         tx_ready_r <= 1'b1;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         div_r      <= div_s;
         bit_cnt_r  <= bit_cnt_s;
         tx_sh_r    <= tx_sh_s;
         rx_sh_r    <= rx_sh_s;
         rx_data_r  <= rx_data_s;
         sclk_r     <= sclk_s;
         mosi_r     <= mosi_s;
         ss_r       <= ss_s;
         rx_valid_r <= rx_valid_s;
         tx_ready_r <= tx_ready_s;
         busy_r     <= busy_s;
      end
   end

   assign tx_ready = tx_ready_r;
   assign busy     = busy_r;
   assign rx_valid = rx_valid_r;
   assign rx_data  = rx_data_r;
   assign sclk     = sclk_r;
   assign mosi     = mosi_r;
   assign ss       = ss_r;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: reset, loopback, constant miso, back-to-back, abort,
// and a behavioural mode-0 slave with a preloaded reply byte.
module tb_spi_master;

   logic       clk;
   logic       rst_n;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       busy;
   logic       sclk;
   logic       mosi;
   logic       miso;
   logic       ss;

   int         total;
   int         bad;

   // miso source: 0 = constant, 1 = loopback of mosi, 2 = slave model
   int         miso_mode;
   logic       miso_const;
   logic [7:0] slv_tx;

   int         rise_cnt;
   int         fall_cnt;
   int         fall_base;
   int         ss_low_cnt;
   int         rv_cnt;
   logic [7:0] rise_bits;
   int         slv_idx;
   logic [7:0] slv_word;

   spi_master #(.DATA_WIDTH(8), .CLK_DIV(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_data  (tx_data),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .busy     (busy),
      .sclk     (sclk),
      .mosi     (mosi),
      .miso     (miso),
      .ss       (ss)
   );

   always #5 clk = ~clk;

   assign slv_idx  = fall_cnt - fall_base;
   assign slv_word = slv_tx << slv_idx;
   assign miso = (miso_mode == 1) ? mosi :
                 (miso_mode == 2) ? ((slv_idx < 8) ? slv_word[7] : 1'b0) : miso_const;

   // Free-running observers; the stimulus block works with differences of these.
   always @(posedge sclk) begin
      rise_cnt  <= rise_cnt + 1;
      rise_bits <= {rise_bits[6:0], mosi};
   end
   always @(negedge sclk) fall_cnt <= fall_cnt + 1;
   always @(negedge ss) fall_base <= fall_cnt;
   always @(posedge clk) begin
      if (ss === 1'b0) ss_low_cnt <= ss_low_cnt + 1;
      if (rx_valid === 1'b1) rv_cnt <= rv_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] d);
      int n;
      n = 0;
      @(negedge clk);
      while (tx_ready !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) chk("ready_timeout", 32'd0, 32'd1);
      tx_valid = 1'b1;
      tx_data  = d;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   // Returns on the negedge where rx_valid is high.
   task automatic wait_rx(input string tag);
      int n;
      n = 0;
      while (rx_valid !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) chk({tag, "_rx_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      int ss0, rv0, rc0, gap, n;
      total = 0; bad = 0;
      clk = 1'b0; rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
      miso_mode = 0; miso_const = 1'b0; slv_tx = 8'h00;
      rise_cnt = 0; fall_cnt = 0; fall_base = 0; ss_low_cnt = 0; rv_cnt = 0; rise_bits = 8'h00;

      idle(3);
      chk("rst_ss", ss, 1'b1);
      chk("rst_sclk", sclk, 1'b0);
      chk("rst_ready", tx_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      idle(2);

      // Loopback 0xA5
      miso_mode = 1;
      ss0 = ss_low_cnt; rv0 = rv_cnt; rc0 = rise_cnt;
      send(8'hA5);
      chk("a5_busy", busy, 1'b1);
      chk("a5_ready", tx_ready, 1'b0);
      wait_rx("a5");
      chk("a5_rx", rx_data, 8'hA5);
      idle(3);
      chk("a5_mosi_bits", rise_bits, 8'hA5);
      chk("a5_rises", rise_cnt - rc0, 32'd8);
      chk("a5_ss_low", ss_low_cnt - ss0, 32'd68);
      chk("a5_rv_pulses", rv_cnt - rv0, 32'd1);
      chk("a5_ss_idle", ss, 1'b1);

      // Asynchronous reset mid-idle, checked before any clk edge
      #2 rst_n = 1'b0;
      #1;
      chk("idle_rst_rx_data", rx_data, 8'h00);
      chk("idle_rst_ss", ss, 1'b1);
      chk("idle_rst_mosi", mosi, 1'b0);
      chk("idle_rst_rv", rx_valid, 1'b0);
      idle(2);
      rst_n = 1'b1;
      idle(2);

      // Constant miso
      miso_mode = 0; miso_const = 1'b1;
      send(8'h00);
      wait_rx("c00");
      chk("c00_rx", rx_data, 8'hFF);
      idle(2);
      chk("c00_mosi_bits", rise_bits, 8'h00);
      miso_const = 1'b0;
      send(8'hFF);
      wait_rx("cff");
      chk("cff_rx", rx_data, 8'h00);
      idle(2);
      chk("cff_mosi_bits", rise_bits, 8'hFF);

      // Back-to-back with tx_valid held high
      miso_mode = 1;
      rv0 = rv_cnt; rc0 = rise_cnt;
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 8'h3C;
      idle(6);
      tx_data  = 8'hC3;
      wait_rx("b2b1");
      chk("b2b1_rx", rx_data, 8'h3C);
      gap = 0;
      while (ss === 1'b1 && gap < 10) begin
         gap++;
         @(negedge clk);
      end
      chk("b2b_gap", gap, 32'd1);
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      wait_rx("b2b2");
      chk("b2b2_rx", rx_data, 8'hC3);
      idle(3);
      chk("b2b_rv_pulses", rv_cnt - rv0, 32'd2);
      chk("b2b_rises", rise_cnt - rc0, 32'd16);

      // Abort after the third sclk rise
      rv0 = rv_cnt; rc0 = rise_cnt;
      send(8'h81);
      n = 0;
      while (rise_cnt - rc0 < 3 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) chk("abort_rise_timeout", 32'd0, 32'd1);
      idle(1);
      chk("abort_pre_sclk", sclk, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_ss", ss, 1'b1);
      chk("abort_sclk", sclk, 1'b0);
      chk("abort_ready", tx_ready, 1'b1);
      idle(2);
      rst_n = 1'b1;
      idle(100);
      chk("abort_no_rv", rv_cnt - rv0, 32'd0);
      ss0 = ss_low_cnt; rv0 = rv_cnt;
      send(8'h5A);
      wait_rx("post_abort");
      chk("post_abort_rx", rx_data, 8'h5A);
      idle(3);
      chk("post_abort_bits", rise_bits, 8'h5A);
      chk("post_abort_ss_low", ss_low_cnt - ss0, 32'd68);
      chk("post_abort_rv", rv_cnt - rv0, 32'd1);

      // Slave model with preloaded reply; tx_data changes mid-frame
      miso_mode = 2; slv_tx = 8'h96;
      send(8'h0D);
      tx_data = 8'hF0;
      idle(20);
      tx_data = 8'h33;
      wait_rx("slave");
      chk("slave_master_rx", rx_data, 8'h96);
      idle(2);
      chk("slave_rx", rise_bits, 8'h0D);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
